// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - scan-code constants, key indices and FSM state for the PS/2 key controller
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_PAUSE = 8'h4D;

  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_PAUSE = 3'd7;

  typedef enum logic {
    FETCH  = 1'b0,
    DECODE = 1'b1
  } state_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// rtl/ps2_key_ctrl_if.sv - receiver FIFO head/pop handshake between ps2_keyboard and ps2_key_ctrl
interface ps2_key_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       rdn;

  modport master (output kbd_data, output kbd_ready, output kbd_overflow, input rdn);
  modport slave  (input kbd_data, input kbd_ready, input kbd_overflow, output rdn);
endinterface

// File: rtl/ps2_keymap.sv
// rtl/ps2_keymap.sv - maps {scan code, E0 flag} to a game key index
// PS2_KEY_CTRL_EXT_EN: arrows only via E0 prefix, other keys only unprefixed.
module ps2_keymap
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [2:0] idx
);

  logic arrow_ok;
  logic plain_ok;

`ifdef PS2_KEY_CTRL_EXT_EN
  assign arrow_ok = ext;
  assign plain_ok = ~ext;
`else
  // Keypad and arrow codes are interchangeable; the E0 flag is never set here.
  logic unused_ext;
  assign unused_ext = ext;
  assign arrow_ok   = 1'b1;
  assign plain_ok   = 1'b1;
`endif

  always_comb begin
    hit = 1'b0;
    idx = KEY_LEFT;
    case (code)
      SC_LEFT:  begin hit = arrow_ok; idx = KEY_LEFT;  end
      SC_RIGHT: begin hit = arrow_ok; idx = KEY_RIGHT; end
      SC_UP:    begin hit = arrow_ok; idx = KEY_UP;    end
      SC_DOWN:  begin hit = arrow_ok; idx = KEY_DOWN;  end
      SC_SPACE: begin hit = plain_ok; idx = KEY_SPACE; end
      SC_ENTER: begin hit = plain_ok; idx = KEY_ENTER; end
      SC_ESC:   begin hit = plain_ok; idx = KEY_ESC;   end
      SC_PAUSE: begin hit = plain_ok; idx = KEY_PAUSE; end
      default:  begin hit = 1'b0;     idx = KEY_LEFT;  end
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code assembler: prefixes, held-key map, event pulses, timeout/overflow recovery
// PS2_KEY_CTRL_EXT_EN: honour E0 prefix (see ps2_keymap); undefined: E0 is consumed and ignored.
module ps2_key_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_W        = 21
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_ctrl_if.slave      kbd,
  output logic [7:0]         keys,
  output logic               evt_valid,
  output logic [7:0]         evt_code,
  output logic               evt_break,
  output logic               evt_ext
);

`ifdef PS2_KEY_CTRL_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  logic [7:0]      byte_q;
  logic            brk_q;
  logic            ext_q;
  logic [TO_W-1:0] to_cnt;
  logic            map_hit;
  logic [2:0]      map_idx;
  logic            pop;

  // Pop is only offered in FETCH, so two pops are always at least 2 cycles apart.
  assign kbd.rdn = rst | (state != FETCH) | ~kbd.kbd_ready;
  assign pop     = ~kbd.rdn;

  ps2_keymap u_keymap (
    .code (byte_q),
    .ext  (ext_q),
    .hit  (map_hit),
    .idx  (map_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      byte_q    <= 8'h00;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      to_cnt    <= '0;
      keys      <= 8'h00;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_break <= 1'b0;
      evt_ext   <= 1'b0;
    end else begin
      evt_valid <= 1'b0;
      if (kbd.kbd_overflow) begin
        state  <= FETCH;
        brk_q  <= 1'b0;
        ext_q  <= 1'b0;
        to_cnt <= '0;
        keys   <= 8'h00;
      end else begin
        if (brk_q | ext_q) begin
          if (to_cnt == TO_LAST) begin
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end else begin
          to_cnt <= '0;
        end

        // Decode assignments come after the timeout so a freshly seen prefix wins.
        case (state)
          FETCH: begin
            if (pop) begin
              byte_q <= kbd.kbd_data;
              to_cnt <= '0;
              state  <= DECODE;
            end
          end
          DECODE: begin
            state <= FETCH;
            if (byte_q == SC_EXT) begin
              ext_q <= EXT_EN;
            end else if (byte_q == SC_BRK) begin
              brk_q <= 1'b1;
            end else begin
              evt_valid <= 1'b1;
              evt_code  <= byte_q;
              evt_break <= brk_q;
              evt_ext   <= ext_q;
              if (map_hit) begin
                keys[map_idx] <= ~brk_q;
              end
              brk_q <= 1'b0;
              ext_q <= 1'b0;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - directed self-checking bench for ps2_key_ctrl
module tb_ps2_key_ctrl;

  localparam int TIMEOUT_CYC = 20;
  localparam int TO_W        = 5;
`ifdef PS2_KEY_CTRL_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;

  ps2_key_ctrl_if kif ();

  ps2_key_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .kbd       (kif),
    .keys      (keys),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_q[$];
  evt_t       evq[$];
  int         pops[$];
  int         cyc = 0;
  bit         prev_low = 1'b0;
  int         rdn_dbl = 0;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  // One cycle of the FIFO model: present head at negedge, observe 1 time unit later.
  task automatic step(input bit ovf);
    @(negedge clk);
    kif.kbd_overflow = ovf;
    kif.kbd_ready    = (tx_q.size() != 0);
    kif.kbd_data     = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    #1;
    cyc++;
    if (evt_valid === 1'b1) evq.push_back('{cyc, evt_code, evt_break, evt_ext});
    if (kif.rdn === 1'b0) begin
      pops.push_back(cyc);
      if (prev_low) rdn_dbl++;
      void'(tx_q.pop_front());
    end
    prev_low = (kif.rdn === 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic clear_logs();
    evq.delete();
    pops.delete();
    rdn_dbl = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_q = '{8'h29};
    step(1'b0);
    step(1'b0);
    chk_cnt++; if (kif.rdn !== 1'b1) $display("FAIL reset_rdn: got %b exp 1", kif.rdn); else pass_cnt++;
    chk_cnt++; if (keys !== 8'h00) $display("FAIL reset_keys: got %h exp 00", keys); else pass_cnt++;
    chk_cnt++; if ({evt_valid, evt_code, evt_break, evt_ext} !== 11'd0)
      $display("FAIL reset_evt: got v=%b c=%h b=%b e=%b exp all 0", evt_valid, evt_code, evt_break, evt_ext); else pass_cnt++;
    tx_q.delete();
    rst = 1'b0;
    run(2);
  endtask

  task automatic test_make_break();
    clear_logs();
    tx_q = '{8'h29};
    run(6);
    chk_cnt++; if (pops.size() != 1) $display("FAIL make_pops: got %0d exp 1", pops.size()); else pass_cnt++;
    chk_cnt++; if (evq.size() != 1) $display("FAIL make_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1 && pops.size() == 1) begin
      chk_cnt++; if (evq[0].code !== 8'h29 || evq[0].brk !== 1'b0 || evq[0].ext !== 1'b0)
        $display("FAIL make_evt: got c=%h b=%b e=%b exp 29/0/0", evq[0].code, evq[0].brk, evq[0].ext); else pass_cnt++;
      chk_cnt++; if (evq[0].cyc - pops[0] != 2) $display("FAIL make_latency: got %0d exp 2", evq[0].cyc - pops[0]); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h10) $display("FAIL make_keys: got %h exp 10", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'hF0, 8'h29};
    run(8);
    chk_cnt++; if (evq.size() != 1) $display("FAIL brk_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].code !== 8'h29 || evq[0].brk !== 1'b1 || evq[0].ext !== 1'b0)
        $display("FAIL brk_evt: got c=%h b=%b e=%b exp 29/1/0", evq[0].code, evq[0].brk, evq[0].ext); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h00) $display("FAIL brk_keys: got %h exp 00", keys); else pass_cnt++;
    chk_cnt++; if (evt_code !== 8'h29 || evt_break !== 1'b1)
      $display("FAIL evt_hold: got c=%h b=%b exp 29/1", evt_code, evt_break); else pass_cnt++;

    clear_logs();
    tx_q = '{8'hF0};
    run(TIMEOUT_CYC + 10);
    chk_cnt++; if (evq.size() != 0) $display("FAIL prefix_only_evcnt: got %0d exp 0", evq.size()); else pass_cnt++;
  endtask

  task automatic test_ext();
    clear_logs();
    tx_q = '{8'hE0, 8'h6B};
    run(8);
    chk_cnt++; if (evq.size() != 1) $display("FAIL ext_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].code !== 8'h6B || evq[0].ext !== EXT || evq[0].brk !== 1'b0)
        $display("FAIL ext_evt: got c=%h e=%b b=%b exp 6b/%b/0", evq[0].code, evq[0].ext, evq[0].brk, EXT); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h01) $display("FAIL ext_keys: got %h exp 01", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'h6B};
    run(6);
    chk_cnt++; if (evq.size() != 1) $display("FAIL keypad_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].ext !== 1'b0) $display("FAIL keypad_ext: got %b exp 0", evq[0].ext); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h01) $display("FAIL keypad_keys: got %h exp 01", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'hE0, 8'hF0, 8'h6B, 8'h1C};
    run(12);
    chk_cnt++; if (evq.size() != 2) $display("FAIL unmapped_evcnt: got %0d exp 2", evq.size()); else pass_cnt++;
    if (evq.size() == 2) begin
      chk_cnt++; if (evq[1].code !== 8'h1C || evq[1].brk !== 1'b0)
        $display("FAIL unmapped_evt: got c=%h b=%b exp 1c/0", evq[1].code, evq[1].brk); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h00) $display("FAIL unmapped_keys: got %h exp 00", keys); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    if (EXT) tx_q = '{8'hE0, 8'h74, 8'hE0, 8'h75, 8'hE0, 8'h72};
    else     tx_q = '{8'h74, 8'h75, 8'h72};
    run(16);
    chk_cnt++; if (rdn_dbl != 0) $display("FAIL b2b_rdn_consec: got %0d exp 0", rdn_dbl); else pass_cnt++;
    chk_cnt++; if (pops.size() != tx_len_exp()) $display("FAIL b2b_pops: got %0d exp %0d", pops.size(), tx_len_exp()); else pass_cnt++;
    if (pops.size() >= 2) begin
      chk_cnt++; if (pops[1] - pops[0] != 2) $display("FAIL b2b_pop_gap: got %0d exp 2", pops[1] - pops[0]); else pass_cnt++;
    end
    chk_cnt++; if (evq.size() != 3) $display("FAIL b2b_evcnt: got %0d exp 3", evq.size()); else pass_cnt++;
    if (evq.size() == 3 && !EXT) begin
      chk_cnt++; if (evq[1].cyc - evq[0].cyc != 2 || evq[2].cyc - evq[1].cyc != 2)
        $display("FAIL b2b_evt_gap: got %0d,%0d exp 2,2", evq[1].cyc - evq[0].cyc, evq[2].cyc - evq[1].cyc); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h0E) $display("FAIL b2b_keys: got %h exp 0e", keys); else pass_cnt++;
  endtask

  function automatic int tx_len_exp();
    return EXT ? 6 : 3;
  endfunction

  task automatic test_timeout();
    tx_q = '{8'hE0, 8'hF0, 8'h74, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h72};
    run(22);
    chk_cnt++; if (keys !== 8'h00) $display("FAIL to_setup_keys: got %h exp 00", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'hE0, 8'hF0};
    run(6);
    run(TIMEOUT_CYC + 5);
    tx_q = '{8'h74};
    run(6);
    chk_cnt++; if (evq.size() != 1) $display("FAIL to_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].code !== 8'h74 || evq[0].brk !== 1'b0 || evq[0].ext !== 1'b0)
        $display("FAIL to_evt: got c=%h b=%b e=%b exp 74/0/0", evq[0].code, evq[0].brk, evq[0].ext); else pass_cnt++;
    end
    chk_cnt++; if (keys !== (EXT ? 8'h00 : 8'h02)) $display("FAIL to_keys: got %h exp %h", keys, EXT ? 8'h00 : 8'h02); else pass_cnt++;

    // Prefix still pending well before the timeout expires.
    clear_logs();
    tx_q = '{8'hF0};
    run(12);
    tx_q = '{8'h29};
    run(6);
    chk_cnt++; if (evq.size() != 1) $display("FAIL early_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].brk !== 1'b1) $display("FAIL early_brk: got %b exp 1", evq[0].brk); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    if (EXT) tx_q = '{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hE0, 8'h75, 8'hE0, 8'h72, 8'h29, 8'h5A, 8'h76, 8'h4D};
    else     tx_q = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A, 8'h76, 8'h4D};
    run(30);
    chk_cnt++; if (keys !== 8'hFF) $display("FAIL ovf_setup_keys: got %h exp ff", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'h29};
    step(1'b1);
    run(5);
    chk_cnt++; if (pops.size() != 1) $display("FAIL ovf_pop: got %0d exp 1", pops.size()); else pass_cnt++;
    chk_cnt++; if (evq.size() != 0) $display("FAIL ovf_evcnt: got %0d exp 0", evq.size()); else pass_cnt++;
    chk_cnt++; if (keys !== 8'h00) $display("FAIL ovf_keys: got %h exp 00", keys); else pass_cnt++;

    clear_logs();
    tx_q = '{8'h5A};
    run(6);
    chk_cnt++; if (evq.size() != 1 || pops.size() != 1) $display("FAIL ovf_fetch_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1 && pops.size() == 1) begin
      chk_cnt++; if (evq[0].cyc - pops[0] != 2) $display("FAIL ovf_fetch_latency: got %0d exp 2", evq[0].cyc - pops[0]); else pass_cnt++;
    end
    chk_cnt++; if (keys !== 8'h20) $display("FAIL ovf_fetch_keys: got %h exp 20", keys); else pass_cnt++;

    // Overflow landing on the decode cycle.
    clear_logs();
    tx_q = '{8'h76};
    step(1'b0);
    step(1'b1);
    run(4);
    chk_cnt++; if (evq.size() != 0) $display("FAIL ovf_dec_evcnt: got %0d exp 0", evq.size()); else pass_cnt++;
    chk_cnt++; if (keys !== 8'h00) $display("FAIL ovf_dec_keys: got %h exp 00", keys); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tx_q = '{8'h29};
    run(6);
    clear_logs();
    tx_q = '{8'hE0};
    run(4);
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    chk_cnt++; if (keys !== 8'h00 || evt_code !== 8'h00 || evt_valid !== 1'b0 || evt_ext !== 1'b0)
      $display("FAIL rst_mid_outs: got k=%h c=%h v=%b e=%b exp 00/00/0/0", keys, evt_code, evt_valid, evt_ext); else pass_cnt++;
    rst = 1'b0;
    clear_logs();
    tx_q = '{8'h75};
    run(6);
    chk_cnt++; if (evq.size() != 1) $display("FAIL rst_mid_evcnt: got %0d exp 1", evq.size()); else pass_cnt++;
    if (evq.size() == 1) begin
      chk_cnt++; if (evq[0].code !== 8'h75 || evq[0].ext !== 1'b0 || evq[0].brk !== 1'b0)
        $display("FAIL rst_mid_evt: got c=%h e=%b b=%b exp 75/0/0", evq[0].code, evq[0].ext, evq[0].brk); else pass_cnt++;
    end
    chk_cnt++; if (keys !== (EXT ? 8'h00 : 8'h04)) $display("FAIL rst_mid_keys: got %h exp %h", keys, EXT ? 8'h00 : 8'h04); else pass_cnt++;
  endtask

  initial begin
    kif.kbd_data     = 8'h00;
    kif.kbd_ready    = 1'b0;
    kif.kbd_overflow = 1'b0;
    test_reset();
    test_make_break();
    test_ext();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

PS/2 scan-code controller sitting between the `ps2_keyboard` receiver FIFO and the game logic. It pops bytes from the receiver via `rdn`, assembles make/break/extended sequences (`E0`, `F0` prefixes), and keeps a held/released state per game key. It also emits a one-cycle event pulse per completed scan code. A prefix timeout and overflow handling keep the key map consistent when bytes are lost.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 2_000_000: cycles a pending prefix may wait for its next byte (20 ms at 100 MHz).
- `TO_W`, default 21: width of the timeout counter. Must satisfy `2**TO_W > TIMEOUT_CYC`.

Ports:
- `clk` in 1: system clock, same domain as the receiver.
- `rst` in 1: synchronous, active-high reset.
- `kbd_data` in 8: receiver FIFO head byte; valid while `kbd_ready` is high.
- `kbd_ready` in 1: receiver FIFO non-empty.
- `kbd_overflow` in 1: receiver FIFO overflow flag.
- `rdn` out 1: active-low pop strobe to the receiver; combinational.
- `keys` out 8: held state, 1 = pressed. Bit assignments:
  - bit 0 left, code `6B`
  - bit 1 right, code `74`
  - bit 2 up, code `75`
  - bit 3 down, code `72`
  - bit 4 space, code `29`
  - bit 5 enter, code `5A`
  - bit 6 esc, code `76`
  - bit 7 P/pause, code `4D`
- `evt_valid` out 1: one-cycle pulse per completed code.
- `evt_code` out 8: final (non-prefix) byte of the event.
- `evt_break` out 1: event was a release (`F0` seen).
- `evt_ext` out 1: event was extended (`E0` seen).

## Operation
- FSM states: `FETCH` and `DECODE`. Reset state is `FETCH`.
- Prefix registers `brk_q` and `ext_q` hold the pending `F0` and `E0` flags.
- FETCH:
  - `rdn = ~kbd_ready`.
  - On the edge where `rdn` is low, latch `kbd_data` into `byte_q` and go to DECODE. The receiver advances its read pointer on the same edge.
- DECODE: `rdn = 1`. Always return to FETCH.
  - `byte_q == E0`: set `ext_q`; no event.
  - `byte_q == F0`: set `brk_q`; no event.
  - Any other byte:
    - Pulse `evt_valid` with `evt_code = byte_q`, `evt_break = brk_q`, `evt_ext = ext_q`.
    - If the byte maps to a key index, set that `keys` bit on make or clear it on break.
    - Clear `brk_q` and `ext_q`.
- Unmapped codes still produce events and leave `keys` unchanged.
- Repeated makes of a held key (typematic) produce events; the `keys` bit stays 1.
- Timeout: while `brk_q | ext_q` is set, a counter increments every cycle. At `TIMEOUT_CYC` it clears both prefixes, with no event. The counter resets on every accepted byte.
- Overflow: any cycle with `kbd_overflow = 1`:
  - `keys` clears to 0, prefixes clear, FSM goes to FETCH.
  - A byte being popped or decoded in that cycle is discarded, with no event. Overflow wins over simultaneous pop or decode.
- Reset outputs:
  - `keys = 0`, `evt_valid = 0`, `evt_code = 00`, `evt_break = 0`, `evt_ext = 0`.
  - `rdn = 1` while `rst` is asserted.
  - Prefixes and counter are 0.
- Reset mid-sequence (for example after `E0 F0`) drops the partial code. A byte that has already been popped is lost.

## Timing
- Throughput: at most one byte per 2 cycles. `rdn` is never low in two consecutive cycles.
- Latency: the pop edge E latches the byte; `keys` and `evt_*` update at edge E+1. `evt_valid` is high for exactly the cycle after E+1.
- `evt_code`, `evt_break` and `evt_ext` hold their value until the next event.
- `rdn` depends only on the current state and `kbd_ready`. No other combinational path exists from inputs to outputs.

## Configuration
- `PS2_KEY_CTRL_EXT_EN` defined:
  - Arrow bits 0–3 respond only to `E0`-prefixed `6B`/`74`/`75`/`72`.
  - Unprefixed codes (keypad 4/6/8/2) produce events only.
  - Bits 4–7 respond only to unprefixed codes.
- Undefined:
  - `E0` is consumed and ignored: `ext_q` is never set, `evt_ext` is always 0.
  - Both keypad and arrow codes drive bits 0–3.

## Structure
- Shared package `ps2_kbd_pkg` holds:
  - Scan-code constants: `SC_EXT = E0`, `SC_BRK = F0`, and the eight key codes.
  - Key-index constants `KEY_LEFT` … `KEY_PAUSE`.
  - The FSM state typedef.
- Sub-module `ps2_keymap`: combinational `{code, ext}` → `{hit, idx[2:0]}`. It contains the `PS2_KEY_CTRL_EXT_EN` selection.
- Top module `ps2_key_ctrl`: FSM, prefix registers, timeout counter, `keys` register.

## Test plan
- Reset, then FIFO supplies `29` → `rdn` low one cycle; at E+1 `keys = 8'h10`, `evt_valid` pulse, `evt_code = 29`, `evt_break = 0`. Then `F0 29` → `keys = 00`, event with `evt_break = 1`. `F0` alone produces no event.
- With EXT_EN: `E0 6B` → `keys[0] = 1`, `evt_ext = 1`. Then `6B` alone → `keys` unchanged, event with `evt_ext = 0`. Without EXT_EN: `6B` → `keys[0] = 1`.
- Back-to-back FIFO bytes `74 75 72`:
  - `rdn` low on alternate cycles only.
  - Three events, 2 cycles apart.
  - Final `keys = 8'h0E`.
- `E0 F0` then no byte for `TIMEOUT_CYC` cycles, then `74` → make event with `evt_ext = 0`, `evt_break = 0`, `keys[1] = 1`.
- Hold `keys = 8'hFF`, raise `kbd_overflow` in the same cycle as a pop → `keys = 00`, no event for that byte, FSM back in FETCH.
- Assert `rst` between `E0` and `75` → all outputs 0; the later `75` decodes as unprefixed.
